// File: rtl/net_bus_arb7.sv
// Seven-requester round-robin NetBus merge arbiter with a per-grant burst limit.
// Accepted beats pass unmodified through a single output register.
module net_bus_arb7 #(
  parameter  int DATA_WIDTH = 4,
  parameter  int BURST_MAX  = 4,
  localparam int W          = DATA_WIDTH * 9 + 14,
  localparam int CW         = $clog2(BURST_MAX + 1)
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic [W-1:0] DATA0,
  input  logic [W-1:0] DATA1,
  input  logic [W-1:0] DATA2,
  input  logic [W-1:0] DATA3,
  input  logic [W-1:0] DATA4,
  input  logic [W-1:0] DATA5,
  input  logic [W-1:0] DATA6,
  input  logic         VALID0,
  input  logic         VALID1,
  input  logic         VALID2,
  input  logic         VALID3,
  input  logic         VALID4,
  input  logic         VALID5,
  input  logic         VALID6,
  output logic         READY0,
  output logic         READY1,
  output logic         READY2,
  output logic         READY3,
  output logic         READY4,
  output logic         READY5,
  output logic         READY6,
  output logic         WCLK,
  output logic [W-1:0] WDATA,
  output logic         WVALID,
  input  logic         WREADY,
  output logic [2:0]   WSRC
);

  logic [6:0]    valid_s;
  logic [W-1:0]  data_s [7];
  logic          load_s;
  logic          any_s;
  logic          stay_s;
  logic [2:0]    sel_s;
  logic [6:0]    ready_s;

  logic [W-1:0]  wdata_q,  wdata_d;
  logic          wvalid_q, wvalid_d;
  logic [2:0]    wsrc_q,   wsrc_d;
  logic [2:0]    last_q,   last_d;
  logic [CW-1:0] cnt_q,    cnt_d;

  // Circular search starting after 'from'; 'from' itself is the last candidate.
  function automatic logic [2:0] rr_pick(input logic [6:0] v, input logic [2:0] from);
    logic [2:0] c;
    logic [2:0] pick;
    logic       hit;
    c    = from;
    pick = from;
    hit  = 1'b0;
    for (int k = 0; k < 7; k++) begin
      c = (c == 3'd6) ? 3'd0 : c + 3'd1;
      if (!hit && v[c]) begin
        pick = c;
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

  assign valid_s = {VALID6, VALID5, VALID4, VALID3, VALID2, VALID1, VALID0};
  assign data_s[0] = DATA0;
  assign data_s[1] = DATA1;
  assign data_s[2] = DATA2;
  assign data_s[3] = DATA3;
  assign data_s[4] = DATA4;
  assign data_s[5] = DATA5;
  assign data_s[6] = DATA6;

  assign load_s  = ~wvalid_q | WREADY;
  assign any_s   = |valid_s;
  assign stay_s  = (cnt_q != {CW{1'b0}}) && (cnt_q < CW'(BURST_MAX)) && valid_s[last_q];
  assign sel_s   = stay_s ? last_q : rr_pick(valid_s, last_q);
  // READY is gated by RST_N so nothing is accepted while reset is held.
  assign ready_s = (RST_N && load_s && any_s) ? (7'd1 << sel_s) : 7'd0;

  assign {READY6, READY5, READY4, READY3, READY2, READY1, READY0} = ready_s;
  assign WCLK   = CLK;
  assign WDATA  = wdata_q;
  assign WVALID = wvalid_q;
  assign WSRC   = wsrc_q;

  // Next-state: accept, idle gap (ends the burst), or stall (hold everything).
  always_comb begin
    wdata_d  = wdata_q;
    wvalid_d = wvalid_q;
    wsrc_d   = wsrc_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    if (load_s) begin
      if (any_s) begin
        wdata_d  = data_s[sel_s];
        wvalid_d = 1'b1;
        wsrc_d   = sel_s;
        last_d   = sel_s;
        cnt_d    = stay_s ? cnt_q + CW'(1) : CW'(1);
      end else begin
        wvalid_d = 1'b0;
        cnt_d    = {CW{1'b0}};
      end
    end else begin
      wvalid_d = wvalid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wdata_q  <= {W{1'b0}};
      wvalid_q <= 1'b0;
      wsrc_q   <= 3'd0;
      last_q   <= 3'd6;
      cnt_q    <= {CW{1'b0}};
    end else begin
      wdata_q  <= wdata_d;
      wvalid_q <= wvalid_d;
      wsrc_q   <= wsrc_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_net_bus_arb7.sv
// Directed self-checking bench for net_bus_arb7 (DATA_WIDTH=4, BURST_MAX=4).
module tb_net_bus_arb7;

  logic        clk;
  logic        rst_n;
  logic [49:0] data [7];
  logic [6:0]  valid;
  logic [6:0]  rdy;
  logic        wclk;
  logic [49:0] wdata;
  logic        wvalid;
  logic        wready;
  logic [2:0]  wsrc;

  int passed;
  int total;

  net_bus_arb7 #(.DATA_WIDTH(4), .BURST_MAX(4)) dut (
    .CLK(clk), .RST_N(rst_n),
    .DATA0(data[0]), .DATA1(data[1]), .DATA2(data[2]), .DATA3(data[3]),
    .DATA4(data[4]), .DATA5(data[5]), .DATA6(data[6]),
    .VALID0(valid[0]), .VALID1(valid[1]), .VALID2(valid[2]), .VALID3(valid[3]),
    .VALID4(valid[4]), .VALID5(valid[5]), .VALID6(valid[6]),
    .READY0(rdy[0]), .READY1(rdy[1]), .READY2(rdy[2]), .READY3(rdy[3]),
    .READY4(rdy[4]), .READY5(rdy[5]), .READY6(rdy[6]),
    .WCLK(wclk), .WDATA(wdata), .WVALID(wvalid), .WREADY(wready), .WSRC(wsrc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [49:0] pat(input int n);
    return {6'd0, 4'(n), 8'hA5, 32'(n)};
  endfunction

  // -1: no READY high, -2: more than one high, else the index.
  function automatic int ready_idx();
    int idx = -1;
    for (int n = 0; n < 7; n++) begin
      if (rdy[n] === 1'b1) idx = (idx == -1) ? n : -2;
    end
    return idx;
  endfunction

  task automatic do_reset();
    rst_n  = 1'b0;
    valid  = 7'd0;
    wready = 1'b1;
    for (int n = 0; n < 7; n++) data[n] = pat(n);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    wready = 1'b1;
    valid  = 7'h7F;
    for (int n = 0; n < 7; n++) data[n] = pat(n);
    @(posedge clk);
    #2;
    total++;
    if (wvalid !== 1'b0 || wdata !== 50'd0 || wsrc !== 3'd0)
      $display("FAIL reset_outs: got wvalid=%b wdata=%h wsrc=%0d want 0/0/0", wvalid, wdata, wsrc);
    else passed++;
    total++;
    if (rdy !== 7'd0) $display("FAIL reset_ready: got %b want 0000000", rdy);
    else passed++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    valid   = 7'b0000100;
    data[2] = 50'h2_0000_0000_0001;
    #1;
    total++;
    if (rdy !== 7'b0000100) $display("FAIL first_ready: got %b want 0000100", rdy);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (wvalid !== 1'b1 || wdata !== 50'h2_0000_0000_0001 || wsrc !== 3'd2)
      $display("FAIL first_beat: got v=%b d=%h s=%0d want 1/2000000000001/2", wvalid, wdata, wsrc);
    else passed++;
  endtask

  task automatic test_round_robin();
    int e;
    do_reset();
    valid = 7'h7F;
    for (int i = 0; i < 29; i++) begin
      e = (i / 4) % 7;
      #1;
      total++;
      if (ready_idx() !== e) $display("FAIL rr_ready beat %0d: got %0d want %0d", i, ready_idx(), e);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (wvalid !== 1'b1 || wsrc !== 3'(e) || wdata !== pat(e))
        $display("FAIL rr_out beat %0d: got v=%b s=%0d want 1/%0d", i, wvalid, wsrc, e);
      else passed++;
    end
  endtask

  task automatic test_stall();
    int seq [5] = '{0, 0, 0, 0, 1};
    do_reset();
    valid = 7'b0000011;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        wready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          #1;
          total++;
          if (rdy !== 7'd0) $display("FAIL stall_ready cyc %0d: got %b want 0000000", s, rdy);
          else passed++;
          @(posedge clk);
          #1;
          total++;
          if (wvalid !== 1'b1 || wsrc !== 3'd0 || wdata !== pat(0))
            $display("FAIL stall_hold cyc %0d: got v=%b s=%0d d=%h want 1/0/%h", s, wvalid, wsrc, wdata, pat(0));
          else passed++;
        end
        wready = 1'b1;
      end
      #1;
      total++;
      if (ready_idx() !== seq[i]) $display("FAIL stall_seq beat %0d: got %0d want %0d", i, ready_idx(), seq[i]);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (wsrc !== 3'(seq[i]) || wvalid !== 1'b1)
        $display("FAIL stall_out beat %0d: got s=%0d want %0d", i, wsrc, seq[i]);
      else passed++;
    end
  endtask

  task automatic test_valid_drop();
    int   seq [7] = '{0, 0, 3, 3, 3, 3, 0};
    logic v0  [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      valid = {3'b000, 1'b1, 2'b00, v0[i]};
      #1;
      total++;
      if (ready_idx() !== seq[i]) $display("FAIL drop_ready beat %0d: got %0d want %0d", i, ready_idx(), seq[i]);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (wsrc !== 3'(seq[i]) || wdata !== pat(seq[i]))
        $display("FAIL drop_out beat %0d: got s=%0d want %0d", i, wsrc, seq[i]);
      else passed++;
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    valid = 7'h7F;
    repeat (18) @(posedge clk);
    #1;
    total++;
    if (wsrc !== 3'd4 || wvalid !== 1'b1) $display("FAIL mid_pre: got s=%0d v=%b want 4/1", wsrc, wvalid);
    else passed++;
    rst_n = 1'b0;
    #1;
    total++;
    if (wvalid !== 1'b0 || wsrc !== 3'd0 || wdata !== 50'd0 || rdy !== 7'd0)
      $display("FAIL mid_async: got v=%b s=%0d r=%b want 0/0/0000000", wvalid, wsrc, rdy);
    else passed++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    total++;
    if (ready_idx() !== 0) $display("FAIL mid_ready: got %0d want 0", ready_idx());
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (wsrc !== 3'd0 || wvalid !== 1'b1) $display("FAIL mid_first: got s=%0d v=%b want 0/1", wsrc, wvalid);
    else passed++;
  endtask

  task automatic test_idle_gap();
    int seq [5] = '{5, 5, 5, 5, 6};
    do_reset();
    valid = 7'b0100000;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (wsrc !== 3'd5 || wvalid !== 1'b1) $display("FAIL gap_pre: got s=%0d v=%b want 5/1", wsrc, wvalid);
    else passed++;
    valid = 7'd0;
    #1;
    total++;
    if (rdy !== 7'd0) $display("FAIL gap_ready: got %b want 0000000", rdy);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (wvalid !== 1'b0) $display("FAIL gap_drain: got wvalid=%b want 0", wvalid);
    else passed++;
    for (int i = 0; i < 5; i++) begin
      valid = (i == 0) ? 7'b0100000 : 7'b1100000;
      #1;
      total++;
      if (ready_idx() !== seq[i]) $display("FAIL gap_seq beat %0d: got %0d want %0d", i, ready_idx(), seq[i]);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (wsrc !== 3'(seq[i]) || wvalid !== 1'b1)
        $display("FAIL gap_out beat %0d: got s=%0d want %0d", i, wsrc, seq[i]);
      else passed++;
    end
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst_n  = 1'b0;
    valid  = 7'd0;
    wready = 1'b1;
    for (int n = 0; n < 7; n++) data[n] = 50'd0;
    test_reset();
    test_round_robin();
    test_stall();
    test_valid_drop();
    test_reset_mid_burst();
    test_idle_gap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
